// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : reset_seq
//  Brief    : Single-clock reset sequencer. Holds all downstream domains in
//             reset for a power-on delay, then releases NUM_DOMAINS active-low
//             resets one at a time in index order with a fixed stagger.
//             Re-runs the sequence on a filtered push-button, a software
//             pulse, or an optional periodic auto-reset.
//  Revision : 1.0 - initial release
// ============================================================================
module reset_seq #(
    parameter int NUM_DOMAINS    = 4,
    parameter int POR_CYCLES     = 700000,
    parameter int STAGGER_CYCLES = 1000,
    parameter int HOLD_CYCLES    = 100,
    parameter int FILTER_CYCLES  = 100,
    parameter int AUTO_PERIOD    = 0,
    parameter int CNT_W          = 32
) (
    input  logic                   clk_100,
    input  logic                   rst_n,
    input  logic                   ext_rst_n,
    input  logic                   soft_rst,
    output logic [NUM_DOMAINS-1:0] rst_out_n,
    output logic                   seq_done,
    output logic [1:0]             state,
    output logic [7:0]             trig_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_POR  = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd1;
    localparam logic [1:0] c_ST_REL  = 2'd2;
    localparam logic [1:0] c_ST_RUN  = 2'd3;

    localparam int c_IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]   c_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_POR_LAST   = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_STAG_LAST  = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_FLT_MAX    = CNT_W'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0]   c_FLT_PRE    = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE    = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_DOMAINS - 1);
    localparam logic [7:0]         c_TRIG_SAT   = 8'hFF;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [NUM_DOMAINS-1:0] r_rst_out;
    logic                   r_seq_done;
    logic [7:0]             r_trig_cnt;

    // Push-button synchroniser and debounce filter
    logic                   r_ext_meta;
    logic                   r_ext_sync;
    logic [CNT_W-1:0]       r_flt_cnt;
    logic                   r_flt_fire;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                   w_flt_active;
    logic                   w_auto_hit;
    logic                   w_trig;
    logic                   w_release;
    logic [1:0]             w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [c_IDX_W-1:0]     w_idx_nxt;
    logic [NUM_DOMAINS-1:0] w_rel_mask;
    logic [NUM_DOMAINS-1:0] w_rst_out_nxt;
    logic                   w_seq_done_nxt;
    logic [7:0]             w_trig_cnt_nxt;

    // ------------------------------------------------------------------------
    // Button path: 2-flop synchroniser, then a consecutive-low counter that
    // saturates at FILTER_CYCLES. r_flt_fire pulses for exactly one cycle on
    // the edge the counter reaches saturation, so a held button yields a
    // single trigger until the synchronised input goes high again.
    // ------------------------------------------------------------------------
    // Synchronise ext_rst_n and debounce it into a one-shot trigger pulse
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            r_ext_meta <= 1'b1;
            r_ext_sync <= 1'b1;
            r_flt_cnt  <= '0;
            r_flt_fire <= 1'b0;
        end else begin
            r_ext_meta <= ext_rst_n;
            r_ext_sync <= r_ext_meta;
            if (r_ext_sync) begin
                r_flt_cnt  <= '0;
                r_flt_fire <= 1'b0;
            end else if (r_flt_cnt != c_FLT_MAX) begin
                r_flt_cnt  <= r_flt_cnt + c_CNT_ONE;
                r_flt_fire <= (r_flt_cnt == c_FLT_PRE);
            end else begin
                r_flt_fire <= 1'b0;
            end
        end
    end

    // Level view of the filter: high for as long as the button is held
    assign w_flt_active = (r_flt_cnt == c_FLT_MAX);

    // ------------------------------------------------------------------------
    // Optional periodic self-trigger, counting cycles spent in RUN
    // ------------------------------------------------------------------------
    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam logic [CNT_W-1:0] c_AUTO_LAST = CNT_W'(AUTO_PERIOD - 1);

            logic [CNT_W-1:0] r_auto_cnt;

            // Count RUN cycles; any trigger or leaving RUN restarts the period
            always_ff @(posedge clk_100) begin
                if (!rst_n || w_trig || (r_state != c_ST_RUN)) begin
                    r_auto_cnt <= '0;
                end else begin
                    r_auto_cnt <= r_auto_cnt + c_CNT_ONE;
                end
            end

            assign w_auto_hit = (r_state == c_ST_RUN) && (r_auto_cnt == c_AUTO_LAST);
        end else begin : g_no_auto
            assign w_auto_hit = 1'b0;
        end
    endgenerate

    // Simultaneous sources merge into a single trigger; POR ignores them all
    assign w_trig = (soft_rst | r_flt_fire | w_auto_hit) && (r_state != c_ST_POR);

    // ------------------------------------------------------------------------
    // FSM state register together with all registered outputs
    // ------------------------------------------------------------------------
    // Commit next-state, counters and output registers
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            r_state    <= c_ST_POR;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_out  <= '0;
            r_seq_done <= 1'b0;
            r_trig_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_rst_out  <= w_rst_out_nxt;
            r_seq_done <= w_seq_done_nxt;
            r_trig_cnt <= w_trig_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. A trigger overrides everything outside POR and forces
    // HOLD with fresh counters, which also covers abort-during-release and
    // restart-during-hold. In HOLD the counter freezes while the button is
    // held, so a stuck button keeps every domain in reset.
    // ------------------------------------------------------------------------
    // Compute next state, phase counter and domain index
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_release   = 1'b0;

        if (w_trig) begin
            w_state_nxt = c_ST_HOLD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_POR: begin
                    if (r_cnt == c_POR_LAST) begin
                        w_state_nxt = c_ST_REL;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_HOLD: begin
                    if (!w_flt_active) begin
                        if (r_cnt == c_HOLD_LAST) begin
                            w_state_nxt = c_ST_REL;
                            w_cnt_nxt   = '0;
                            w_idx_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_CNT_ONE;
                        end
                    end
                end

                c_ST_REL: begin
                    if (r_cnt == c_STAG_LAST) begin
                        w_cnt_nxt = '0;
                        w_release = 1'b1;
                        if (r_idx == c_IDX_LAST) begin
                            w_state_nxt = c_ST_RUN;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt   = r_idx + c_IDX_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_RUN: begin
                    w_cnt_nxt = '0;
                end

                default: begin
                    w_state_nxt = c_ST_POR;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // One-hot mask of the domain selected for release at this stagger point
    always_comb begin
        w_rel_mask = '0;
        for (int k = 0; k < NUM_DOMAINS; k++) begin
            w_rel_mask[k] = (r_idx == c_IDX_W'(k));
        end
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------------
    // Re-assert all domains on a trigger, otherwise release one per stagger
    always_comb begin
        w_rst_out_nxt  = r_rst_out;
        w_seq_done_nxt = r_seq_done;
        w_trig_cnt_nxt = r_trig_cnt;

        if (w_trig) begin
            w_rst_out_nxt  = '0;
            w_seq_done_nxt = 1'b0;
            if (r_trig_cnt != c_TRIG_SAT) begin
                w_trig_cnt_nxt = r_trig_cnt + 8'd1;
            end
        end else if (w_release) begin
            w_rst_out_nxt = r_rst_out | w_rel_mask;
            if (w_state_nxt == c_ST_RUN) begin
                w_seq_done_nxt = 1'b1;
            end
        end
    end

    assign rst_out_n = r_rst_out;
    assign seq_done  = r_seq_done;
    assign state     = r_state;
    assign trig_cnt  = r_trig_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_seq
//  Brief    : Directed self-checking bench for reset_seq. One instance runs
//             the POR / soft / button / abort / simultaneous / mid-reset
//             scenarios; a second instance with AUTO_PERIOD = 50 exercises
//             the periodic self-trigger and trig_cnt saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reset_seq;

    logic clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    // Main instance signals
    logic       rst_n;
    logic       ext_rst_n;
    logic       soft_rst;
    logic [3:0] rst_out_n;
    logic       seq_done;
    logic [1:0] state;
    logic [7:0] trig_cnt;

    // Auto-reset instance signals
    logic       a_rst_n;
    logic       a_ext_rst_n;
    logic       a_soft_rst;
    logic [3:0] a_rst_out_n;
    logic       a_seq_done;
    logic [1:0] a_state;
    logic [7:0] a_trig_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    reset_seq #(
        .NUM_DOMAINS   (4),
        .POR_CYCLES    (20),
        .STAGGER_CYCLES(5),
        .HOLD_CYCLES   (8),
        .FILTER_CYCLES (10),
        .AUTO_PERIOD   (0),
        .CNT_W         (32)
    ) dut (
        .clk_100  (clk_100),
        .rst_n    (rst_n),
        .ext_rst_n(ext_rst_n),
        .soft_rst (soft_rst),
        .rst_out_n(rst_out_n),
        .seq_done (seq_done),
        .state    (state),
        .trig_cnt (trig_cnt)
    );

    reset_seq #(
        .NUM_DOMAINS   (4),
        .POR_CYCLES    (20),
        .STAGGER_CYCLES(5),
        .HOLD_CYCLES   (8),
        .FILTER_CYCLES (10),
        .AUTO_PERIOD   (50),
        .CNT_W         (32)
    ) dut_auto (
        .clk_100  (clk_100),
        .rst_n    (a_rst_n),
        .ext_rst_n(a_ext_rst_n),
        .soft_rst (a_soft_rst),
        .rst_out_n(a_rst_out_n),
        .seq_done (a_seq_done),
        .state    (a_state),
        .trig_cnt (a_trig_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance to just after rising edge number 'target' (counted from rst_n release)
    task automatic tick_to(input int target);
        while (cyc < target) begin
            @(posedge clk_100);
            #1;
            cyc++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int x;
        rst_n       = 1'b0;
        ext_rst_n   = 1'b1;
        soft_rst    = 1'b0;
        a_rst_n     = 1'b0;
        a_ext_rst_n = 1'b1;
        a_soft_rst  = 1'b0;

        repeat (3) @(posedge clk_100);
        #1;
        check_eq("rst_state",    32'(state),     32'd0);
        check_eq("rst_out",      32'(rst_out_n), 32'h0);
        check_eq("rst_seq_done", 32'(seq_done),  32'd0);
        check_eq("rst_trig_cnt", 32'(trig_cnt),  32'd0);
        rst_n = 1'b1;
        cyc   = 0;

        // Power-on sequence: REL at edge 20, bits at 25/30/35/40
        tick_to(19); check_eq("por_state19", 32'(state), 32'd0);
        tick_to(20); check_eq("por_state20", 32'(state), 32'd2);
        tick_to(24); check_eq("por_out24",   32'(rst_out_n), 32'h0);
        tick_to(25); check_eq("por_out25",   32'(rst_out_n), 32'h1);
        tick_to(30); check_eq("por_out30",   32'(rst_out_n), 32'h3);
        tick_to(35); check_eq("por_out35",   32'(rst_out_n), 32'h7);
        tick_to(39); check_eq("por_state39", 32'(state), 32'd2);
                     check_eq("por_done39",  32'(seq_done), 32'd0);
        tick_to(40); check_eq("por_out40",   32'(rst_out_n), 32'hF);
                     check_eq("por_state40", 32'(state), 32'd3);
                     check_eq("por_done40",  32'(seq_done), 32'd1);

        // Soft reset in RUN: sampled at edge 46, REL at 54, RUN at 74
        tick_to(45); soft_rst = 1'b1;
        tick_to(46); soft_rst = 1'b0;
        check_eq("soft_state46", 32'(state), 32'd1);
        check_eq("soft_out46",   32'(rst_out_n), 32'h0);
        check_eq("soft_done46",  32'(seq_done), 32'd0);
        check_eq("soft_trig46",  32'(trig_cnt), 32'd1);
        tick_to(53); check_eq("soft_state53", 32'(state), 32'd1);
        tick_to(54); check_eq("soft_state54", 32'(state), 32'd2);
        tick_to(58); check_eq("soft_out58",   32'(rst_out_n), 32'h0);
        tick_to(59); check_eq("soft_out59",   32'(rst_out_n), 32'h1);
        tick_to(74); check_eq("soft_out74",   32'(rst_out_n), 32'hF);
                     check_eq("soft_state74", 32'(state), 32'd3);

        // Button low for 9 cycles only: filter never saturates
        tick_to(80); ext_rst_n = 1'b0;
        tick_to(89); ext_rst_n = 1'b1;
        tick_to(100);
        check_eq("short_state", 32'(state), 32'd3);
        check_eq("short_trig",  32'(trig_cnt), 32'd1);

        // Button held 30 cycles: trigger at edge 113, REL 8 counting edges after clearing
        ext_rst_n = 1'b0;
        tick_to(112); check_eq("btn_state112", 32'(state), 32'd3);
        tick_to(113); check_eq("btn_state113", 32'(state), 32'd1);
                      check_eq("btn_trig113",  32'(trig_cnt), 32'd2);
        tick_to(125); check_eq("btn_state125", 32'(state), 32'd1);
        tick_to(130); ext_rst_n = 1'b1;
        tick_to(140); check_eq("btn_state140", 32'(state), 32'd1);
        tick_to(141); check_eq("btn_state141", 32'(state), 32'd2);
                      check_eq("btn_trig141",  32'(trig_cnt), 32'd2);
        tick_to(161); check_eq("btn_state161", 32'(state), 32'd3);

        // Abort mid-release: HOLD 171, REL 179, bit1 at 189, abort at 191
        tick_to(170); soft_rst = 1'b1;
        tick_to(171); soft_rst = 1'b0;
        check_eq("abt_trig171", 32'(trig_cnt), 32'd3);
        tick_to(189); check_eq("abt_out189", 32'(rst_out_n), 32'h3);
        tick_to(190); soft_rst = 1'b1;
        check_eq("abt_out190", 32'(rst_out_n), 32'h3);
        tick_to(191); soft_rst = 1'b0;
        check_eq("abt_out191",   32'(rst_out_n), 32'h0);
        check_eq("abt_state191", 32'(state), 32'd1);
        check_eq("abt_trig191",  32'(trig_cnt), 32'd4);
        tick_to(199); check_eq("abt_state199", 32'(state), 32'd2);
        tick_to(203); check_eq("abt_out203",   32'(rst_out_n), 32'h0);
        tick_to(204); check_eq("abt_out204",   32'(rst_out_n), 32'h1);
        tick_to(209); check_eq("abt_out209",   32'(rst_out_n), 32'h3);
        tick_to(219); check_eq("abt_state219", 32'(state), 32'd3);

        // Soft and filtered button in the same cycle: one trigger at edge 238
        tick_to(225); ext_rst_n = 1'b0;
        tick_to(237); soft_rst = 1'b1;
        check_eq("sim_trig237", 32'(trig_cnt), 32'd4);
        tick_to(238); soft_rst = 1'b0;
        check_eq("sim_trig238",  32'(trig_cnt), 32'd5);
        check_eq("sim_state238", 32'(state), 32'd1);
        tick_to(240); check_eq("sim_trig240", 32'(trig_cnt), 32'd5);

        // rst_n during HOLD: everything clears, POR restarts from edge 248
        tick_to(245); rst_n = 1'b0; ext_rst_n = 1'b1;
        tick_to(246);
        check_eq("mid_state", 32'(state), 32'd0);
        check_eq("mid_trig",  32'(trig_cnt), 32'd0);
        check_eq("mid_out",   32'(rst_out_n), 32'h0);
        check_eq("mid_done",  32'(seq_done), 32'd0);
        tick_to(247); rst_n = 1'b1;
        tick_to(266); check_eq("rpor_state266", 32'(state), 32'd0);
        tick_to(267); check_eq("rpor_state267", 32'(state), 32'd2);
        tick_to(271); check_eq("rpor_out271",   32'(rst_out_n), 32'h0);
        tick_to(272); check_eq("rpor_out272",   32'(rst_out_n), 32'h1);

        // Auto-reset: RUN at x+40, triggers at x+90 + 78*n
        tick_to(280); a_rst_n = 1'b1;
        x = 280;
        tick_to(x + 39);  check_eq("auto_state39",  32'(a_state), 32'd2);
        tick_to(x + 40);  check_eq("auto_state40",  32'(a_state), 32'd3);
                          check_eq("auto_done40",   32'(a_seq_done), 32'd1);
        tick_to(x + 89);  check_eq("auto_state89",  32'(a_state), 32'd3);
                          check_eq("auto_trig89",   32'(a_trig_cnt), 32'd0);
        tick_to(x + 90);  check_eq("auto_state90",  32'(a_state), 32'd1);
                          check_eq("auto_trig90",   32'(a_trig_cnt), 32'd1);
                          check_eq("auto_out90",    32'(a_rst_out_n), 32'h0);
        tick_to(x + 167); check_eq("auto_state167", 32'(a_state), 32'd3);
        tick_to(x + 168); check_eq("auto_state168", 32'(a_state), 32'd1);
                          check_eq("auto_trig168",  32'(a_trig_cnt), 32'd2);
        tick_to(x + 90 + 78 * 253); check_eq("auto_trig254", 32'(a_trig_cnt), 32'd254);
        tick_to(x + 90 + 78 * 254); check_eq("auto_trig255", 32'(a_trig_cnt), 32'd255);
        tick_to(x + 90 + 78 * 255); check_eq("auto_sat256",  32'(a_trig_cnt), 32'd255);
                                    check_eq("auto_st256",   32'(a_state), 32'd1);
        tick_to(x + 90 + 78 * 299 + 10); check_eq("auto_sat300", 32'(a_trig_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Parametrised single-clock reset sequencer. Successor to the board-level reset generator.
- Holds all downstream domains in reset for a power-on delay, then releases NUM_DOMAINS active-low resets one by one in index order with a fixed stagger.
- After that it re-runs the sequence on any of three triggers: a filtered external button, a software pulse, or an optional periodic auto-reset used for soak testing.
- Sits at the top level, ahead of the per-clock-domain reset synchronisers.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset outputs (1..16).
- POR_CYCLES, 700000, cycles held in power-on delay after rst_n deasserts (>=1).
- STAGGER_CYCLES, 1000, cycles between successive domain releases (>=1).
- HOLD_CYCLES, 100, minimum cycles all outputs stay asserted after a trigger (>=1).
- FILTER_CYCLES, 100, consecutive synchronised-low samples of ext_rst_n needed to trigger (>=1).
- AUTO_PERIOD, 0, cycles in RUN before a self-trigger; 0 disables auto-reset.
- CNT_W, 32, width of internal counters; must hold the largest parameter value.

Ports:
- clk_100, input, 1, system clock.
- rst_n, input, 1, synchronous active-low block reset.
- ext_rst_n, input, 1, asynchronous active-low push-button; the block synchronises it internally.
- soft_rst, input, 1, single-cycle software reset request, synchronous to clk_100.
- rst_out_n, output, NUM_DOMAINS, active-low domain resets; bit k is released k-th.
- seq_done, output, 1, high when all domains are released (state RUN).
- state, output, 2, 0 = POR, 1 = HOLD, 2 = REL, 3 = RUN.
- trig_cnt, output, 8, saturating count of accepted triggers.

Behaviour:
- Interface: one clock, clk_100. rst_n is synchronous and active-low.
- Clock edge with rst_n = 0:
  - state <= POR, rst_out_n <= all 0, seq_done <= 0, trig_cnt <= 0.
  - All counters and the domain index are cleared; the 2-flop ext_rst_n synchroniser is set to 1.
- All outputs are registered. There is no combinational path from any input to any output.
- Edge numbering: edge 1 is the first rising edge with rst_n = 1.
- POR state:
  - cnt increments each edge.
  - At the edge where cnt == POR_CYCLES-1: go to REL, cnt <= 0, idx <= 0.
  - All triggers are ignored.
- REL state:
  - cnt increments each edge.
  - At the edge where cnt == STAGGER_CYCLES-1: rst_out_n[idx] <= 1, cnt <= 0, idx <= idx+1.
  - When the released idx is NUM_DOMAINS-1: go to RUN and set seq_done <= 1 on the same edge.
  - After power-on, domain k is released at edge POR_CYCLES + (k+1)*STAGGER_CYCLES.
- RUN state: outputs are static. The auto counter runs only when AUTO_PERIOD > 0.
- Trigger sources:
  - soft_rst = 1.
  - Filter output: a consecutive-low counter on the synchronised ext_rst_n reaches FILTER_CYCLES. The counter clears on any high sample and saturates at FILTER_CYCLES.
  - Auto counter == AUTO_PERIOD-1.
  - Simultaneous sources count as one trigger.
- Trigger accepted in REL, RUN or HOLD:
  - Next edge: state <= HOLD, rst_out_n <= all 0, seq_done <= 0, cnt <= 0, idx <= 0, auto counter <= 0.
  - trig_cnt increments and saturates at 255.
  - A trigger during REL aborts the release; already-released domains are re-asserted.
  - A trigger during HOLD restarts the hold count.
- HOLD state:
  - cnt advances only while the filter output is inactive; a held button keeps the block in HOLD indefinitely.
  - At cnt == HOLD_CYCLES-1 with the button not held: go to REL, cnt <= 0.
  - A held button counts as one trigger. It re-triggers only after the synchronised input returns high.
- Latency:
  - ext_rst_n falling edge to trigger: 2 synchroniser cycles + FILTER_CYCLES.
  - Trigger to rst_out_n low: 1 edge.
- No wrap: all counters compare for equality and reset on the transition, so they cannot exceed their terminal values.

Test Plan:
- POR sequencing: POR_CYCLES = 20, STAGGER_CYCLES = 5, NUM_DOMAINS = 4; rst_n low 3 cycles, then high -> rst_out_n bits rise at edges 25, 30, 35, 40; seq_done = 1 and state = 3 from edge 40; rst_out_n = 4'b0000 before edge 25.
- Soft reset in RUN: HOLD_CYCLES = 8; pulse soft_rst for 1 cycle -> rst_out_n = 0 and state = 1 the next edge; REL entered 8 edges later; domains re-release at 5-cycle spacing; trig_cnt = 1.
- Button filter: FILTER_CYCLES = 10; ext_rst_n low for 9 cycles, then high -> no trigger. Held low for 30 cycles -> exactly one trigger, stays in HOLD until release + 8 cycles; trig_cnt increments by 1 only.
- Abort mid-release: soft_rst one cycle after rst_out_n[1] rises -> all bits 0 next edge; after hold the sequence restarts from bit 0.
- Auto-reset: AUTO_PERIOD = 50 -> a trigger 50 cycles after each entry to RUN, repeating; trig_cnt saturates at 255 after 300 periods.
- Reset mid-operation and simultaneous triggers: rst_n low during HOLD -> state = 0, trig_cnt = 0, POR restarts. soft_rst and filtered button in the same cycle -> trig_cnt increments by 1.
